ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single cache-line RAM channel, driven by the RCU, between NREQ cache requesters (default 2: instruction cache on port 0, data cache on port 1).
- Selects one requester round-robin and latches its address, write line and rnw for the whole transaction.
- Drives the RCU request inputs, returns the RCU acknowledge to the granted requester only, and guarantees the idle gap the RCU needs between transactions.
- Watches transaction length and flags a sticky timeout when a transaction exceeds its cycle limit.

Parameters:
- NREQ, 2, number of requesters (2..8).
- ADDR_W, 32, address width.
- LINE_W, 512, cache line width.
- TIMEOUT_CYCLES, 1024, cycles from grant without RCU ack before the timeout flag sets.
- CNT_W, 11, width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset: sampled on clk, 0 = reset.
- req_avalid  in  NREQ  per-requester request valid, held until that requester's ack.
- req_rnw  in  NREQ  per-requester 1=read, 0=write.
- req_addr  in  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NREQ*LINE_W  packed write lines.
- req_ack  out  NREQ  one-hot, one-cycle completion pulse.
- rcu_avalid  out  1  request valid to RCU (cache_avalid).
- rcu_rnw  out  1  to RCU cache_rnw.
- rcu_addr  out  ADDR_W  latched address.
- rcu_wdata  out  LINE_W  latched write line.
- rcu_ack  in  1  RCU cache_ack.
- grant_id  out  $clog2(NREQ)  index of current or last owner.
- busy  out  1  transaction in flight.
- timeout_err  out  NREQ  sticky per-requester watchdog flag.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, rr_ptr=0, watchdog=0.
  - All outputs 0: req_ack, rcu_avalid, rcu_rnw, rcu_addr, rcu_wdata, grant_id, busy, timeout_err.
  - A transaction in flight is abandoned; the RCU is reset with the same rst, so no state is resynchronised.
- All outputs are registered. There is no combinational path from any input to any output.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_avalid bit is set, pick the first set bit at or after rr_ptr, wrapping around.
  - Latch that requester's rnw, addr and wdata, set grant_id, set busy=1, set rcu_avalid=1, clear the watchdog, go to ISSUE.
  - Latency is 1 cycle from request to rcu_avalid.
- ISSUE:
  - rcu_avalid and the latched fields stay constant; the RCU re-samples avalid/rnw after leaving its idle state.
  - Watchdog increments every cycle. When it reaches TIMEOUT_CYCLES, set timeout_err[grant_id]; the counter saturates and the transaction keeps waiting.
  - When rcu_ack=1: set rcu_avalid=0 and req_ack[grant_id]=1, go to RESP.
  - rcu_avalid is therefore low in the cycle the RCU is back in its idle state, so no spurious restart occurs.
- RESP (exactly 1 cycle):
  - req_ack returns to 0, busy=0, rr_ptr=grant_id+1 modulo NREQ, go to IDLE.
  - No new grant is issued in RESP. This gives a guaranteed minimum gap of 2 cycles with rcu_avalid=0.
- Requests seen in ISSUE or RESP are not lost; they are evaluated in the next IDLE.
- A requester deasserting req_avalid after grant is a protocol violation. The arbiter ignores it and completes with the latched values.
- rcu_ack while in IDLE or RESP is ignored.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,..,NREQ-1,0; no requester waits more than NREQ-1 transactions.
- timeout_err bits clear only on reset.

Decomposition:
- Shared defs include/package holds:
  - state encoding localparams (IDLE=0, ISSUE=1, RESP=2; 2-bit);
  - LINE_W=512 and ADDR_W defaults, shared with the RCU and the cache;
  - the $clog2 helper.
- One sub-module, rr_pick: combinational rotate-priority picker.
  - Inputs: NREQ-bit request vector and rr_ptr.
  - Outputs: valid and index.
  - Verified standalone.

Test Plan:
- Single read: req_avalid=01, rnw=1, addr=0x100; RCU model acks 25 cycles later.
  - rcu_avalid rises 1 cycle after the request; rcu_addr=0x100.
  - req_ack=01 for exactly 1 cycle, in the cycle after rcu_ack.
  - rcu_avalid=0 in that same cycle.
- Contention: both requesters assert in the same cycle from reset.
  - Grant 0 first, then 1.
  - With both held continuously for 6 transactions, grant_id sequence is 0,1,0,1,0,1.
- Back-to-back: requester 1 keeps avalid high after its ack.
  - rcu_avalid stays 0 for at least 2 cycles between transactions.
  - The RCU model never sees avalid high in its idle state right after its ack cycle.
- Latching: after grant, change req_addr to 0xDEAD and req_wdata, and drop req_avalid.
  - rcu_addr and rcu_wdata keep the originally latched values until completion.
- Timeout: TIMEOUT_CYCLES=16 and the RCU withholds ack.
  - timeout_err[grant_id] sets on cycle 16 after grant.
  - A late ack still completes normally; timeout_err remains set.
- Reset mid-transaction: rst=0 while in ISSUE.
  - Next cycle all outputs are 0 and state is IDLE.
  - A new request is then granted starting from requester 0.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the cache-line RAM port arbiter.
// State encoding, default bus widths and index-width helper.
package ram_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Rotate-priority picker: first set request at or after ptr,
// wrapping around.
module rr_pick
  import ram_port_arbiter_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  int j;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NREQ;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RCU cache-line channel
// between NREQ requesters, with per-requester watchdog.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter  int NREQ           = 2,
  parameter  int ADDR_W         = ADDR_W_DEF,
  parameter  int LINE_W         = LINE_W_DEF,
  parameter  int TIMEOUT_CYCLES = 1024,
  parameter  int CNT_W          = 11,
  localparam int IW             = idx_w(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_avalid,
  input  logic [NREQ-1:0]          req_rnw,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*LINE_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ack,
  output logic                     rcu_avalid,
  output logic                     rcu_rnw,
  output logic [ADDR_W-1:0]        rcu_addr,
  output logic [LINE_W-1:0]        rcu_wdata,
  input  logic                     rcu_ack,
  output logic [IW-1:0]            grant_id,
  output logic                     busy,
  output logic [NREQ-1:0]          timeout_err
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  state_t              state_q, state_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [CNT_W-1:0]    wd_q, wd_d;
  logic [IW-1:0]       gid_q, gid_d;
  logic                busy_q, busy_d;
  logic                avalid_q, avalid_d;
  logic                rnw_q, rnw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [NREQ-1:0]     terr_q, terr_d;

  logic                pick_v;
  logic [IW-1:0]       pick_idx;
  logic                sel_rnw;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LINE_W-1:0]   sel_wdata;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (req_avalid),
    .ptr   (rr_q),
    .valid (pick_v),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_rnw   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(pick_idx) == i) begin
        sel_rnw   = req_rnw[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*LINE_W +: LINE_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    wd_d     = wd_q;
    gid_d    = gid_q;
    busy_d   = busy_q;
    avalid_d = avalid_q;
    rnw_d    = rnw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack_d    = '0;
    terr_d   = terr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_v) begin
          state_d  = ISSUE;
          gid_d    = pick_idx;
          rnw_d    = sel_rnw;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          busy_d   = 1'b1;
          avalid_d = 1'b1;
          wd_d     = '0;
        end
      end
      ISSUE: begin
        if (wd_q != TMO) wd_d = wd_q + 1'b1;
        if (rcu_ack) begin
          avalid_d = 1'b0;
          ack_d    = NREQ'(1) << gid_q;
          state_d  = RESP;
        end else if (wd_d == TMO) begin
          terr_d = terr_q | (NREQ'(1) << gid_q);
        end
      end
      RESP: begin
        // No grant here: keeps avalid low for two cycles.
        busy_d  = 1'b0;
        rr_d    = (int'(gid_q) == NREQ - 1) ? '0 : gid_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      wd_q     <= '0;
      gid_q    <= '0;
      busy_q   <= 1'b0;
      avalid_q <= 1'b0;
      rnw_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack_q    <= '0;
      terr_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      wd_q     <= wd_d;
      gid_q    <= gid_d;
      busy_q   <= busy_d;
      avalid_q <= avalid_d;
      rnw_q    <= rnw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      terr_q   <= terr_d;
    end
  end

  assign req_ack     = ack_q;
  assign rcu_avalid  = avalid_q;
  assign rcu_rnw     = rnw_q;
  assign rcu_addr    = addr_q;
  assign rcu_wdata   = wdata_q;
  assign grant_id    = gid_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter (NREQ=2, short watchdog).
// Drives and samples 1 time unit after each rising edge.
module tb_ram_port_arbiter;

  localparam int NREQ   = 2;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 512;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NREQ-1:0]        req_avalid = '0;
  logic [NREQ-1:0]        req_rnw = '0;
  logic [NREQ*ADDR_W-1:0] req_addr = '0;
  logic [NREQ*LINE_W-1:0] req_wdata = '0;
  logic [NREQ-1:0]        req_ack;
  logic                   rcu_avalid;
  logic                   rcu_rnw;
  logic [ADDR_W-1:0]      rcu_addr;
  logic [LINE_W-1:0]      rcu_wdata;
  logic                   rcu_ack = 1'b0;
  logic                   grant_id;
  logic                   busy;
  logic [NREQ-1:0]        timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [LINE_W-1:0] wd_a;
  logic [LINE_W-1:0] wd_b;

  ram_port_arbiter #(
    .NREQ           (NREQ),
    .ADDR_W         (ADDR_W),
    .LINE_W         (LINE_W),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (11)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_avalid  (req_avalid),
    .req_rnw     (req_rnw),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ack     (req_ack),
    .rcu_avalid  (rcu_avalid),
    .rcu_rnw     (rcu_rnw),
    .rcu_addr    (rcu_addr),
    .rcu_wdata   (rcu_wdata),
    .rcu_ack     (rcu_ack),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    req_avalid = '0;
    rcu_ack    = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Wait for grant, ack after lat cycles, check ack pulse and gap.
  task automatic txn(input int exp_gid, input int lat);
    int   n;
    logic held;
    logic [ADDR_W-1:0] a0;
    n = 0;
    while (!rcu_avalid && n < 8) begin
      tick();
      n++;
    end
    check("grant_seen", 64'(rcu_avalid), 64'd1);
    check("grant_id", 64'(grant_id), 64'(exp_gid));
    held = 1'b1;
    a0   = rcu_addr;
    for (int k = 0; k < lat - 1; k++) begin
      tick();
      held &= rcu_avalid & (rcu_addr == a0);
    end
    check("issue_held", 64'(held), 64'd1);
    rcu_ack = 1'b1;
    tick();
    rcu_ack = 1'b0;
    check("req_ack", 64'(req_ack), 64'(1 << exp_gid));
    check("ack_avalid_lo", 64'(rcu_avalid), 64'd0);
    tick();
    check("gap_avalid_lo", 64'(rcu_avalid), 64'd0);
    check("ack_cleared", 64'(req_ack), 64'd0);
    check("busy_cleared", 64'(busy), 64'd0);
  endtask

  initial begin
    wd_a = {8{64'h0123_4567_89AB_CDEF}};
    wd_b = ~wd_a;

    // Reset state
    do_reset();
    check("rst_req_ack", 64'(req_ack), 64'd0);
    check("rst_avalid", 64'(rcu_avalid), 64'd0);
    check("rst_rnw", 64'(rcu_rnw), 64'd0);
    check("rst_addr", 64'(rcu_addr), 64'd0);
    check("rst_wdata", rcu_wdata[63:0], 64'd0);
    check("rst_gid", 64'(grant_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_terr", 64'(timeout_err), 64'd0);

    // Stray ack in IDLE is ignored
    rcu_ack = 1'b1;
    tick();
    rcu_ack = 1'b0;
    tick();
    check("idle_ack_ignored", 64'(req_ack), 64'd0);
    check("idle_ack_busy", 64'(busy), 64'd0);

    // Single read, ack 25 cycles after grant
    req_avalid = 2'b01;
    req_rnw    = 2'b01;
    req_addr[0 +: ADDR_W] = 32'h100;
    check("pre_avalid", 64'(rcu_avalid), 64'd0);
    tick();
    check("rd_latency", 64'(rcu_avalid), 64'd1);
    check("rd_addr", 64'(rcu_addr), 64'h100);
    check("rd_rnw", 64'(rcu_rnw), 64'd1);
    check("rd_busy", 64'(busy), 64'd1);
    txn(0, 25);
    req_avalid = '0;

    // Contention from reset: alternating grants
    do_reset();
    req_avalid = 2'b11;
    req_rnw    = 2'b11;
    for (int t = 0; t < 6; t++) txn(t % 2, 3);
    req_avalid = '0;

    // Back-to-back from requester 1 alone
    do_reset();
    req_avalid = 2'b10;
    req_addr[ADDR_W +: ADDR_W] = 32'h340;
    txn(1, 2);
    tick();
    check("b2b_regrant", 64'(rcu_avalid), 64'd1);
    check("b2b_addr", 64'(rcu_addr), 64'h340);
    txn(1, 2);
    req_avalid = '0;

    // Latching: inputs change and request drops after grant
    do_reset();
    req_avalid = 2'b01;
    req_rnw    = 2'b00;
    req_addr[0 +: ADDR_W]  = 32'h2000;
    req_wdata[0 +: LINE_W] = wd_a;
    tick();
    check("wr_rnw", 64'(rcu_rnw), 64'd0);
    req_addr[0 +: ADDR_W]  = 32'hDEAD;
    req_wdata[0 +: LINE_W] = wd_b;
    req_avalid = '0;
    tick();
    tick();
    tick();
    check("latch_addr", 64'(rcu_addr), 64'h2000);
    check("latch_wd_lo", rcu_wdata[63:0], wd_a[63:0]);
    check("latch_wd_hi", rcu_wdata[511:448], wd_a[511:448]);
    check("latch_avalid", 64'(rcu_avalid), 64'd1);
    txn(0, 2);

    // Watchdog: flag on the 16th cycle after grant
    do_reset();
    req_avalid = 2'b10;
    req_addr[ADDR_W +: ADDR_W] = 32'h300;
    tick();
    check("to_granted", 64'(rcu_avalid), 64'd1);
    repeat (15) tick();
    check("to_not_yet", 64'(timeout_err), 64'd0);
    tick();
    check("to_set", 64'(timeout_err), 64'b10);
    repeat (4) tick();
    check("to_still_busy", 64'(busy), 64'd1);
    txn(1, 3);
    req_avalid = '0;
    tick();
    check("to_sticky", 64'(timeout_err), 64'b10);

    // Reset mid-transaction restarts round-robin at 0
    do_reset();
    req_avalid = 2'b01;
    txn(0, 2);
    req_avalid = 2'b11;
    tick();
    check("mid_gid_before", 64'(grant_id), 64'd1);
    tick();
    tick();
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    tick();
    check("mid_rst_avalid", 64'(rcu_avalid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_gid", 64'(grant_id), 64'd0);
    check("mid_rst_addr", 64'(rcu_addr), 64'd0);
    check("mid_rst_ack", 64'(req_ack), 64'd0);
    rst = 1'b1;
    tick();
    check("post_rst_avalid", 64'(rcu_avalid), 64'd1);
    check("post_rst_gid", 64'(grant_id), 64'd0);
    req_avalid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
